// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receive controller.
// Synchronises the raw RX line, finds the start edge, enables the external
// baud generator for the duration of a frame and assembles the data bits
// on each mid-bit sample pulse. Good frames raise rx_done with the new
// byte; a low stop bit raises frame_err and leaves rx_data unchanged.
module uart_rx_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  input  logic                 clk_bps,
  output logic                 count_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [2:0] LastIdx = 3'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 fall;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic [2:0]           bit_idx_q;
  logic                 rx_done_q;
  logic                 frame_err_q;

  // Two-flop synchroniser plus an edge-detect flop; all reset high so that
  // leaving reset on an idle line never looks like a start edge.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;

  // Frame state register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start on a falling edge, then advance only on sample pulses.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (clk_bps) state_d = sync2_q ? IDLE : DATA;
      end
      DATA: begin
        if (clk_bps && (bit_idx_q == LastIdx)) state_d = STOP;
      end
      STOP: begin
        if (clk_bps) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: LSB-first shift register, bit counter, output byte and strobes.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bit_idx_q   <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (clk_bps) begin
        unique case (state_q)
          START: begin
            bit_idx_q <= '0;
          end
          DATA: begin
            shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q != LastIdx) bit_idx_q <= bit_idx_q + 3'd1;
          end
          STOP: begin
            if (sync2_q) begin
              rx_data_q <= shift_q;
              rx_done_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Outputs: the baud enable and busy flag cover every non-idle state.
  always_comb begin
    count_sig = (state_q != IDLE);
    rx_busy   = (state_q != IDLE);
    rx_data   = rx_data_q;
    rx_done   = rx_done_q;
    frame_err = frame_err_q;
  end

endmodule
